// File: rtl/stream_demux_buffered_if.sv
// Upstream/downstream handshake bundle for the one-to-N stream demultiplexer.
// slave = the demux itself, master = the producer/consumers around it.
interface stream_demux_buffered_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
);
  logic                   up_valid;
  logic                   up_ready;
  logic [WIDTH-1:0]       up_data;
  logic [SEL_W-1:0]       up_sel;
  logic [N_OUT-1:0]       down_valid;
  logic [N_OUT-1:0]       down_ready;
  logic [N_OUT*WIDTH-1:0] down_data;
  logic                   drop_pulse;

  modport master (
    output up_valid, up_data, up_sel, down_ready,
    input  up_ready, down_valid, down_data, drop_pulse
  );

  modport slave (
    input  up_valid, up_data, up_sel, down_ready,
    output up_ready, down_valid, down_data, drop_pulse
  );
endinterface

// File: rtl/stream_demux_buffered.sv
// One-to-N stream demultiplexer: each beat is steered by its select field into a
// one-entry register per downstream channel; out-of-range selects are dropped.
module stream_demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             free
);
  // Free when empty or draining this cycle, so a load can overlap a drain.
  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module stream_demux_buffered #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input logic                    clk,
  input logic                    rst,
  stream_demux_buffered_if.slave bus
);
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t                         up;
  logic                          sel_ok;
  logic                          sel_free;
  logic                          accept;
  logic [N_OUT-1:0]              lane_load;
  logic [N_OUT-1:0]              lane_free;
  logic [N_OUT-1:0]              lane_vld;
  logic [N_OUT-1:0][WIDTH-1:0]   lane_data;
  logic                          drop_q;

  assign up     = '{sel: bus.up_sel, data: bus.up_data};
  assign sel_ok = 32'(up.sel) < 32'(N_OUT);

  // Out-of-range selects match no lane and fall through as ready.
  always_comb begin
    sel_free = 1'b1;
    for (int i = 0; i < N_OUT; i++)
      if (up.sel == SEL_W'(i)) sel_free = lane_free[i];
  end

  assign bus.up_ready = sel_free;
  assign accept       = bus.up_valid && sel_free;

  genvar g;
  generate
    for (g = 0; g < N_OUT; g++) begin : g_lane
      assign lane_load[g] = accept && (up.sel == SEL_W'(g));

      stream_demux_lane #(.WIDTH(WIDTH)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .load  (lane_load[g]),
        .din   (up.data),
        .ready (bus.down_ready[g]),
        .valid (lane_vld[g]),
        .dout  (lane_data[g]),
        .free  (lane_free[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= accept && !sel_ok;
  end

  assign bus.down_valid = lane_vld;
  assign bus.down_data  = lane_data;
  assign bus.drop_pulse = drop_q;
endmodule

// File: tb/tb_stream_demux_buffered.sv
// Directed bench for the stream demux: per-channel expected queues are filled on
// acceptance and drained by a monitor on every downstream transfer.
module tb_stream_demux_buffered;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  stream_demux_buffered_if #(.WIDTH(W), .N_OUT(4), .SEL_W(2)) b4();
  stream_demux_buffered_if #(.WIDTH(W), .N_OUT(3), .SEL_W(2)) b3();

  stream_demux_buffered #(.WIDTH(W), .N_OUT(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
  stream_demux_buffered #(.WIDTH(W), .N_OUT(3), .SEL_W(2)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] eq4 [4][64];
  logic [7:0] eq3 [3][64];
  int wp4 [4] = '{default: 0};
  int rp4 [4] = '{default: 0};
  int wp3 [3] = '{default: 0};
  int rp3 [3] = '{default: 0};
  int drops3 = 0;
  int drops4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: pop on every valid&&ready downstream transfer.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst4 && b4.down_valid[i] && b4.down_ready[i]) begin
        if (rp4[i] == wp4[i]) begin
          n_cmp++; n_bad++;
          $display("FAIL dut4 ch%0d unexpected beat: got %0h want none", i, b4.down_data[i*W +: W]);
        end else begin
          chk($sformatf("dut4 ch%0d data", i), 32'(b4.down_data[i*W +: W]), 32'(eq4[i][rp4[i] % 64]));
          rp4[i]++;
        end
      end
    for (int i = 0; i < 3; i++)
      if (!rst3 && b3.down_valid[i] && b3.down_ready[i]) begin
        if (rp3[i] == wp3[i]) begin
          n_cmp++; n_bad++;
          $display("FAIL dut3 ch%0d unexpected beat: got %0h want none", i, b3.down_data[i*W +: W]);
        end else begin
          chk($sformatf("dut3 ch%0d data", i), 32'(b3.down_data[i*W +: W]), 32'(eq3[i][rp3[i] % 64]));
          rp3[i]++;
        end
      end
    if (b3.drop_pulse) drops3++;
    if (b4.drop_pulse) drops4++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one beat, wait (bounded) for up_ready, record the expectation, then step past the edge.
  task automatic send(input bit d3, input logic [7:0] d, input logic [1:0] s, output int stall);
    stall = 0;
    if (d3) begin b3.up_valid = 1'b1; b3.up_data = d; b3.up_sel = s; end
    else    begin b4.up_valid = 1'b1; b4.up_data = d; b4.up_sel = s; end
    @(negedge clk);
    while (!(d3 ? b3.up_ready : b4.up_ready)) begin
      stall++;
      if (stall > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send timeout: data %0h sel %0d never accepted", d, s);
        tick();
        return;
      end
      tick();
      @(negedge clk);
    end
    if (d3) begin
      if (s < 3) begin eq3[s][wp3[s] % 64] = d; wp3[s]++; end
    end else begin
      eq4[s][wp4[s] % 64] = d; wp4[s]++;
    end
    tick();
  endtask

  task automatic idle();
    b4.up_valid = 1'b0;
    b3.up_valid = 1'b0;
  endtask

  initial begin
    int st;
    int tot;
    b4.up_valid = 0; b4.up_data = 0; b4.up_sel = 0; b4.down_ready = 4'h0;
    b3.up_valid = 0; b3.up_data = 0; b3.up_sel = 0; b3.down_ready = 3'h0;
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b0; rst3 = 1'b0;

    // Reset then idle
    @(negedge clk);
    chk("rst down_valid4", 32'(b4.down_valid), 32'h0);
    chk("rst down_data4", b4.down_data, 32'h0);
    chk("rst drop4", 32'(b4.drop_pulse), 32'h0);
    chk("rst down_valid3", 32'(b3.down_valid), 32'h0);
    chk("rst down_data3", 32'(b3.down_data), 32'h0);
    for (int s = 0; s < 4; s++) begin
      b4.up_sel = 2'(s); b3.up_sel = 2'(s); #1;
      chk($sformatf("idle up_ready4 sel%0d", s), 32'(b4.up_ready), 32'h1);
      chk($sformatf("idle up_ready3 sel%0d", s), 32'(b3.up_ready), 32'h1);
    end
    tick();

    // Single beat with one-cycle latency
    b4.down_ready = 4'hF;
    send(0, 8'hA5, 2, st);
    idle();
    @(negedge clk);
    chk("single valid", 32'(b4.down_valid), 32'h4);
    chk("single data", 32'(b4.down_data[23:16]), 32'hA5);
    @(negedge clk);
    chk("single drained", 32'(b4.down_valid), 32'h0);
    tick();

    // Back-pressure on channel 1
    b4.down_ready = 4'b1101;
    send(0, 8'h11, 1, st);
    b4.up_data = 8'h22; b4.up_sel = 2'd1;
    repeat (5) begin
      @(negedge clk);
      chk("bp up_ready low", 32'(b4.up_ready), 32'h0);
      chk("bp hold data", 32'(b4.down_data[15:8]), 32'h11);
      chk("bp hold valid", 32'(b4.down_valid[1]), 32'h1);
      tick();
    end
    b4.down_ready = 4'hF;
    send(0, 8'h22, 1, st);
    chk("bp ready same cycle", 32'(st), 32'h0);
    idle();
    @(negedge clk);
    chk("bp replaced data", 32'(b4.down_data[15:8]), 32'h22);
    tick();

    // Full rate fan-out
    tot = 0;
    for (int d = 0; d < 16; d++) begin
      send(0, 8'(d), 2'(d % 4), st);
      tot += st;
    end
    idle();
    chk("full rate stalls", 32'(tot), 32'h0);
    repeat (2) tick();

    // Independent stall: channel 0 blocked
    b4.down_ready = 4'b1110;
    send(0, 8'h30, 0, st);
    tot = 0;
    send(0, 8'h41, 1, st); tot += st;
    send(0, 8'h43, 3, st); tot += st;
    send(0, 8'h45, 1, st); tot += st;
    send(0, 8'h47, 3, st); tot += st;
    idle();
    chk("indep stalls", 32'(tot), 32'h0);
    @(negedge clk);
    chk("indep ch0 data", 32'(b4.down_data[7:0]), 32'h30);
    chk("indep ch0 valid", 32'(b4.down_valid[0]), 32'h1);
    tick();
    b4.up_valid = 1'b1; b4.up_data = 8'h31; b4.up_sel = 2'd0;
    repeat (3) begin
      @(negedge clk);
      chk("indep ch0 stalls", 32'(b4.up_ready), 32'h0);
      tick();
    end
    b4.down_ready = 4'hF;
    send(0, 8'h31, 0, st);
    chk("indep ch0 release", 32'(st), 32'h0);
    idle();
    repeat (2) tick();

    // Drop on N_OUT=3
    send(1, 8'h60, 1, st);
    send(1, 8'h44, 3, st);
    chk("drop accepted", 32'(st), 32'h0);
    idle();
    @(negedge clk);
    chk("drop pulse", 32'(b3.drop_pulse), 32'h1);
    chk("drop valid unchanged", 32'(b3.down_valid), 32'h2);
    chk("drop ch1 data", 32'(b3.down_data[15:8]), 32'h60);
    @(negedge clk);
    chk("drop pulse one cycle", 32'(b3.drop_pulse), 32'h0);
    tick();

    // Mid-operation reset with stalled channels
    send(1, 8'h50, 0, st);
    send(1, 8'h52, 2, st);
    idle();
    @(negedge clk);
    chk("pre-reset valid", 32'(b3.down_valid), 32'h7);
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) rp3[i] = wp3[i];
    @(negedge clk);
    chk("mid reset valid", 32'(b3.down_valid), 32'h0);
    chk("mid reset data", 32'(b3.down_data), 32'h0);
    tick();

    // Drain and account for every expected beat
    b4.down_ready = 4'hF; b3.down_ready = 3'h7;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("dut4 ch%0d leftover", i), 32'(wp4[i] - rp4[i]), 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("dut3 ch%0d leftover", i), 32'(wp3[i] - rp3[i]), 32'h0);
    chk("dut3 drop count", 32'(drops3), 32'h1);
    chk("dut4 drop count", 32'(drops4), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_demux_buffered.md
Name: stream_demux_buffered

Overview:
Sequential one-to-N demultiplexer with valid/ready handshakes. It is the inverse of the mux primitive: a single upstream stream is steered to one of N_OUT downstream channels, chosen by a select field carried with each beat. Each downstream channel has a one-entry output register, so steering is registered and back-pressure is handled per channel. Used wherever a shared producer must fan out beats to independent consumers.

Parameters:
WIDTH, 8, data width of every beat
N_OUT, 4, number of downstream channels (2..16)
SEL_W, $clog2(N_OUT), width of the select field

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
up_valid  input  1  upstream beat present
up_ready  output  1  block can accept the upstream beat this cycle
up_data  input  WIDTH  upstream payload
up_sel  input  SEL_W  destination channel index for the current beat
down_valid  output  N_OUT  bit i: channel i holds a beat
down_ready  input  N_OUT  bit i: consumer i accepts this cycle
down_data  output  N_OUT*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH]
drop_pulse  output  1  one-cycle pulse: an accepted beat had up_sel >= N_OUT and was discarded

Behaviour:
- Transfer rule: a beat moves on any interface only when valid && ready are both high in the same cycle.
- Reset: when rst=1 at a clock edge, all down_valid bits go to 0, all down_data goes to 0, and drop_pulse goes to 0. Reset mid-operation discards every buffered beat. No beat is accepted in the reset cycle.
- up_ready is combinational from up_sel, down_valid and down_ready. It does not depend on up_valid.
  - If up_sel >= N_OUT: up_ready = 1.
  - Otherwise: up_ready = !down_valid[up_sel] || down_ready[up_sel].
- Per channel i, at each clock edge, in priority order:
  1. If rst: valid_i <= 0, data_i <= 0.
  2. Else if the upstream beat is accepted and up_sel == i: valid_i <= 1, data_i <= up_data. This case covers a load and a drain in the same cycle.
  3. Else if down_ready[i]: valid_i <= 0, and data_i holds.
  4. Else the channel holds its state.
- Latency: a beat accepted at edge k appears on down_valid and down_data after edge k (1 cycle).
- Throughput: one beat per cycle to the same channel while that consumer keeps down_ready=1. Channels are independent.
- Stability: while down_valid[i]=1 and down_ready[i]=0, down_data for channel i must not change, and down_valid[i] must not fall.
- down_ready[i] asserted while down_valid[i]=0 has no effect.
- Out-of-range select (possible only when N_OUT is not a power of two): the beat is accepted, no channel changes, and drop_pulse=1 for exactly the cycle after acceptance. Otherwise drop_pulse=0.
- Ordering: beats sent to the same channel leave in acceptance order. No ordering is defined across different channels.
- Only one channel can be loaded per cycle. A blocked channel blocks up_ready only when the current beat targets that channel (head-of-line blocking on the upstream stream is accepted).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 with up_valid=0 -> down_valid=0000, down_data=0, drop_pulse=0, up_ready=1 for every up_sel.
- Single beat: up_data=8'hA5, up_sel=2, up_valid=1 for 1 cycle, down_ready=1111 -> next cycle down_valid=0100 and channel 2 data=A5. The cycle after that, down_valid=0000.
- Back-pressure: load 8'h11 to channel 1 with down_ready[1]=0, then offer 8'h22 to channel 1 -> up_ready=0, and channel 1 holds 11 for 5 cycles. Then raise down_ready[1] -> up_ready=1 in the same cycle, 22 replaces 11 on the next edge, and no beat is lost.
- Full rate with fan-out: 16 consecutive beats with data=0..15 and up_sel=data%4, all down_ready=1 -> up_ready stays 1. Each channel sees its beats in order (ch0: 0,4,8,12 ...), one beat per cycle overall.
- Independent stall: channel 0 blocked with down_ready[0]=0 while beats target channels 1 and 3 -> those beats flow with no stall and channel 0 data is unchanged. A beat targeting channel 0 stalls until down_ready[0]=1.
- Drop and mid-reset: N_OUT=3, beat with up_sel=3 -> accepted, drop_pulse=1 for one cycle, down_valid unchanged. Separately, with channels 0 and 2 loaded and stalled, assert rst for 1 cycle -> down_valid=000 on the next cycle.
